// File: rtl/vis_pkg.sv
// Shared definitions for the visibility frame packer: FSM states,
// header layout and the default header tag.
package vis_pkg;

    // Width of the completed-frame counter carried in the header.
    localparam int FRAME_CNT_W = 16;

    // Default header tag byte.
    localparam logic [7:0] VIS_MAGIC_DEFAULT = 8'hA5;

    // Header word layout: {magic[31:24], 8'h00[23:16], frame_cnt[15:0]}.
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_CNT_LSB   = 0;

    // Packer FSM. The encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_RE   = 2'd2,
        ST_IM   = 2'd3
    } vis_state_e;

    // Build the frame header word from the tag byte and the frame counter.
    function automatic logic [31:0] make_header(input logic [7:0]             magic,
                                                input logic [FRAME_CNT_W-1:0] cnt);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8]         = magic;
        w[HDR_CNT_LSB +: FRAME_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/sext32.sv
// Sign-extends a W-bit two's complement value to a 32-bit word.
// Widths above 32 cannot be represented and stop elaboration.
module sext32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    output logic [31:0]  out_o
);

    // Reject widths that cannot be packed into one 32-bit word.
    generate
        if (W < 1 || W > 32) begin : g_bad_width
            $error("sext32: width W=%0d must be within 1..32", W);
        end
    endgenerate

    // A signed size cast replicates the top bit into the upper word bits.
    assign out_o = 32'($signed(in_i));

endmodule

// File: rtl/vis_frame_packer.sv
// Visibility frame packer: turns a stream of (re, im) visibilities into
// 32-bit words framed as header, then RE/IM pairs, with a frame counter
// and a one-cycle flag for frames whose length differs from NVIS.
//
// Input handshake: a visibility is accepted on a clock edge where
// s_valid_i & s_ready_o; s_ready_o is only ever high in IM and simply
// follows m_tready_i there. Upstream holds re/im/last stable from the
// moment s_valid_i rises until that acceptance, because RE and IM words
// are driven straight from the held inputs. Output words transfer on
// m_tvalid_o & m_tready_i; data, last and head stay stable while stalled.
module vis_frame_packer
    import vis_pkg::*;
#(
    parameter int                     ACCUM         = 32,
    parameter int                     NVIS          = 16,
    parameter logic [7:0]             MAGIC         = VIS_MAGIC_DEFAULT,
    // Value the frame counter takes on reset (zero in normal use).
    parameter logic [FRAME_CNT_W-1:0] FRAME_CNT_RST = '0
) (
    input  logic                   bus_clock,
    input  logic                   bus_reset,
    input  logic [ACCUM-1:0]       s_revis_i,
    input  logic [ACCUM-1:0]       s_imvis_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic                   s_last_i,
    output logic [31:0]            m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic                   m_thead_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   len_err_o,
    output logic [1:0]             dbg_state_o
);

    localparam int                IDX_W    = (NVIS > 1) ? $clog2(NVIS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NVIS - 1);

    // A frame must hold at least one visibility.
    generate
        if (NVIS < 1) begin : g_bad_nvis
            $error("vis_frame_packer: NVIS=%0d must be at least 1", NVIS);
        end
    endgenerate

    vis_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   m_tvalid_q;
    logic                   m_thead_q;

    logic [31:0]            re_word;
    logic [31:0]            im_word;
    logic                   at_last_idx;
    logic                   frame_end;
    logic                   out_fire;
    logic                   im_fire;

    sext32 #(.W(ACCUM)) u_sext_re (
        .in_i  (s_revis_i),
        .out_o (re_word)
    );

    sext32 #(.W(ACCUM)) u_sext_im (
        .in_i  (s_imvis_i),
        .out_o (im_word)
    );

    // The frame closes on an explicit last or when NVIS visibilities are in.
    assign at_last_idx = (idx_q == IDX_LAST);
    assign frame_end   = s_last_i | at_last_idx;
    assign out_fire    = m_tvalid_q & m_tready_i;
    assign im_fire     = (state_q == ST_IM) & out_fire;

    // FSM, visibility index, frame counter and registered valid/head flags.
    always_ff @(posedge bus_clock) begin
        if (bus_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            frame_cnt_q <= FRAME_CNT_RST;
            m_tvalid_q  <= 1'b0;
            m_thead_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pending visibility opens a frame; nothing is consumed yet.
                    if (s_valid_i) begin
                        state_q    <= ST_HEAD;
                        m_tvalid_q <= 1'b1;
                        m_thead_q  <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (out_fire) begin
                        state_q   <= ST_RE;
                        m_thead_q <= 1'b0;
                    end
                end
                ST_RE: begin
                    if (out_fire) begin
                        state_q <= ST_IM;
                    end
                end
                ST_IM: begin
                    // The IM word transfer is also the input acceptance.
                    if (out_fire) begin
                        if (frame_end) begin
                            state_q     <= ST_IDLE;
                            m_tvalid_q  <= 1'b0;
                            idx_q       <= '0;
                            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        end else begin
                            state_q <= ST_RE;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    m_tvalid_q <= 1'b0;
                    m_thead_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output word select: header from the counter, RE/IM from the held inputs.
    always_comb begin
        m_tdata_o = '0;
        case (state_q)
            ST_HEAD: m_tdata_o = make_header(MAGIC, frame_cnt_q);
            ST_RE:   m_tdata_o = re_word;
            ST_IM:   m_tdata_o = im_word;
            default: m_tdata_o = '0;
        endcase
    end

    // Short frame (early last) or long frame (no last at NVIS) both flag here.
    assign len_err_o   = im_fire & (s_last_i ^ at_last_idx);
    assign m_tlast_o   = (state_q == ST_IM) & frame_end;
    assign s_ready_o   = (state_q == ST_IM) & m_tready_i;
    assign m_tvalid_o  = m_tvalid_q;
    assign m_thead_o   = m_thead_q;
    assign frame_cnt_o = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule
